dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, word address width.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports Req0/Req1  input  1  access request from port 0 (CPU) / port 1 (DMA).
REQ-006 SHALL have ports We0/We1  input  1  1 = write, 0 = read, qualified by ReqN.
REQ-007 SHALL have ports Addr0/Addr1  input  ADDR_WIDTH  word address.
REQ-008 SHALL have ports WData0/WData1  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports Gnt0/Gnt1  output  1  one-cycle pulse: request accepted.
REQ-010 SHALL have ports RValid0/RValid1  output  1  one-cycle pulse: RDataN valid.
REQ-011 SHALL have ports RData0/RData1  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have port MemAddr  output  ADDR_WIDTH  address to data memory.
REQ-013 SHALL have port MemWriteData  output  DATA_WIDTH  write data to data memory.
REQ-014 SHALL have ports MemWrite/MemRead  output  1  memory strobes.
REQ-015 SHALL have port MemDataRead  input  DATA_WIDTH  combinational read data from memory.
REQ-016 SHALL have port Busy  output  1  high while in ACCESS state.

Function
REQ-017 SHALL implement FSM with states IDLE and ACCESS.
REQ-018 SHALL, in IDLE with any ReqN high at edge, latch winner's We/Addr/WData and port id, move to ACCESS, and drive GntN high for exactly the ACCESS cycle.
REQ-019 SHALL arbitrate round-robin: if both request, grant the port not granted most recently (LastGnt); a single requester wins unconditionally.
REQ-020 SHALL update LastGnt to the granted port on every grant.
REQ-021 SHALL, in ACCESS, drive MemAddr/MemWriteData from latched command, MemWrite = latched We, MemRead = ~latched We.
REQ-022 SHALL drive MemWrite = MemRead = 0 in IDLE; MemAddr/MemWriteData hold last latched values.
REQ-023 SHALL, at the edge ending an ACCESS read, capture MemDataRead into RDataN of the granted port and pulse RValidN for the following cycle; the other port's RData is unchanged.
REQ-024 SHALL never pulse RValidN for writes.
REQ-025 SHALL return from ACCESS to IDLE unconditionally after one cycle; requests during ACCESS are ignored (not queued).
REQ-026 SHALL give read latency: Req sampled at edge T -> Gnt during cycle T+1 -> RValid/RData during T+2; peak throughput one access per 2 cycles.
REQ-027 SHALL require requesters to hold ReqN and fields stable until GntN and to deassert ReqN in the Gnt cycle; a still-high ReqN after Gnt is a new request.
REQ-028 SHALL gate MemWrite and MemRead with ~Reset so no memory write occurs in a cycle where Reset is high.

Reset
REQ-029 SHALL, on Reset high at edge, enter IDLE; Gnt0/1, RValid0/1, Busy, MemWrite, MemRead = 0; RData0/1, MemAddr, MemWriteData = 0; LastGnt = port 1 (port 0 wins first tie).
REQ-030 SHALL abort an in-progress ACCESS on Reset: no RValid pulse, no write performed.

Verification
REQ-031 SHALL cover: after reset, Req0 read Addr=5 with mem[5]=0xDEADBEEF -> Gnt0 next cycle with MemRead=1, MemAddr=5; RValid0=1, RData0=0xDEADBEEF the cycle after.
REQ-032 SHALL cover: Req1 write Addr=3 WData=0x1234 -> Gnt1, MemWrite=1 one cycle; later port-0 read of Addr 3 returns 0x1234; RValid1 never asserted.
REQ-033 SHALL cover: Req0 and Req1 held continuously, re-asserted after each Gnt -> grants alternate 0,1,0,1 with one grant every 2 cycles.
REQ-034 SHALL cover: simultaneous first requests after reset -> port 0 granted first.
REQ-035 SHALL cover: Reset asserted during ACCESS of a write to Addr 7 -> mem[7] unchanged, no RValid, all outputs at reset values next cycle.
REQ-036 SHALL cover: Req1 raised during port-0 ACCESS -> ignored that cycle, granted in the next ACCESS.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two data-memory requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  Req0;
    logic                  Req1;
    logic                  We0;
    logic                  We1;
    logic [ADDR_WIDTH-1:0] Addr0;
    logic [ADDR_WIDTH-1:0] Addr1;
    logic [DATA_WIDTH-1:0] WData0;
    logic [DATA_WIDTH-1:0] WData1;
    logic                  Gnt0;
    logic                  Gnt1;
    logic                  RValid0;
    logic                  RValid1;
    logic [DATA_WIDTH-1:0] RData0;
    logic [DATA_WIDTH-1:0] RData1;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [DATA_WIDTH-1:0] MemWriteData;
    logic                  MemWrite;
    logic                  MemRead;
    logic [DATA_WIDTH-1:0] MemDataRead;
    logic                  Busy;

    modport slave (
        input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, MemDataRead,
        output Gnt0, Gnt1, RValid0, RValid1, RData0, RData1,
               MemAddr, MemWriteData, MemWrite, MemRead, Busy
    );

    modport master (
        output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, MemDataRead,
        input  Gnt0, Gnt1, RValid0, RValid1, RData0, RData1,
               MemAddr, MemWriteData, MemWrite, MemRead, Busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory (port 0 CPU, port 1 DMA).
// Each accepted access takes one ACCESS cycle; reads return registered data on the following cycle.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  grant_s;
    logic                  winner_s;
    logic                  last_gnt_r;
    logic                  port_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  rvalid0_r;
    logic                  rvalid1_r;
    logic [DATA_WIDTH-1:0] rdata0_r;
    logic [DATA_WIDTH-1:0] rdata1_r;
    logic                  access_s;
    logic                  read_done0_s;
    logic                  read_done1_s;

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and round-robin winner selection; ties go to the port not granted last
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        winner_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.Req0 && bus.Req1) begin
                    grant_s      = 1'b1;
                    winner_s     = ~last_gnt_r;
                    state_next_s = ACCESS;
                end else if (bus.Req0 || bus.Req1) begin
                    grant_s      = 1'b1;
                    winner_s     = bus.Req1;
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Latch the winning command and remember who won
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_gnt_r <= 1'b1;
            port_r     <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
        end else if (grant_s) begin
            last_gnt_r <= winner_s;
            port_r     <= winner_s;
            we_r       <= winner_s ? bus.We1    : bus.We0;
            addr_r     <= winner_s ? bus.Addr1  : bus.Addr0;
            wdata_r    <= winner_s ? bus.WData1 : bus.WData0;
        end
    end

    assign access_s     = (state_r == ACCESS);
    assign read_done0_s = access_s && !we_r && !port_r;
    assign read_done1_s = access_s && !we_r &&  port_r;

    // Capture read data at the end of a read ACCESS; a reset in that cycle aborts the return
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= '0;
            rdata1_r  <= '0;
        end else begin
            rvalid0_r <= read_done0_s;
            rvalid1_r <= read_done1_s;
            if (read_done0_s) begin
                rdata0_r <= bus.MemDataRead;
            end
            if (read_done1_s) begin
                rdata1_r <= bus.MemDataRead;
            end
        end
    end

    // Strobes are masked by Reset so an aborted write never reaches memory
    assign bus.MemWrite     = access_s &&  we_r && !Reset;
    assign bus.MemRead      = access_s && !we_r && !Reset;
    assign bus.MemAddr      = addr_r;
    assign bus.MemWriteData = wdata_r;
    assign bus.Busy         = access_s;
    assign bus.Gnt0         = access_s && !port_r;
    assign bus.Gnt1         = access_s &&  port_r;
    assign bus.RValid0      = rvalid0_r;
    assign bus.RValid1      = rvalid1_r;
    assign bus.RData0       = rdata0_r;
    assign bus.RData1       = rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random two-port traffic,
// compared every cycle against a transaction-level model with its own memory image.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    assign bus.MemDataRead = mem[bus.MemAddr[3:0]];

    int n_checks = 0;
    int n_pass   = 0;

    // Model: an accepted access is "pending" for one cycle, then completes at the next edge
    logic        m_last;
    logic        pend_v;
    logic        pend_port;
    logic        pend_we;
    logic [31:0] pend_addr;
    logic [31:0] pend_wdata;
    logic        e_gnt0, e_gnt1, e_rv0, e_rv1, e_busy;
    logic [31:0] e_rd0, e_rd1, e_addr, e_wdata;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_edge(input logic rst,
                              input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        logic finished;
        logic win;
        finished = 1'b0;
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_busy = 1'b0;
        if (pend_v) begin
            finished = 1'b1;
            if (!rst) begin
                if (pend_we) ref_mem[pend_addr[3:0]] = pend_wdata;
                else if (pend_port == 1'b0) begin e_rd0 = ref_mem[pend_addr[3:0]]; e_rv0 = 1'b1; end
                else begin e_rd1 = ref_mem[pend_addr[3:0]]; e_rv1 = 1'b1; end
            end
            pend_v = 1'b0;
        end
        if (rst) begin
            m_last = 1'b1; pend_v = 1'b0; pend_we = 1'b0;
            e_rd0 = 32'h0; e_rd1 = 32'h0; e_addr = 32'h0; e_wdata = 32'h0;
        end else if (!finished && (r0 || r1)) begin
            if (r0 && r1) win = (m_last == 1'b1) ? 1'b0 : 1'b1;
            else          win = r1;
            m_last     = win;
            pend_v     = 1'b1;
            pend_port  = win;
            pend_we    = win ? w1 : w0;
            pend_addr  = win ? a1 : a0;
            pend_wdata = win ? d1 : d0;
            e_addr     = pend_addr;
            e_wdata    = pend_wdata;
            e_busy     = 1'b1;
            e_gnt0     = !win;
            e_gnt1     = win;
        end
    endtask

    task automatic drive(input logic rst,
                         input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        Reset      = rst;
        bus.Req0   = r0; bus.We0 = w0; bus.Addr0 = a0; bus.WData0 = d0;
        bus.Req1   = r1; bus.We1 = w1; bus.Addr1 = a1; bus.WData1 = d1;
    endtask

    task automatic step();
        logic        s_rst, s_r0, s_w0, s_r1, s_w1, mw;
        logic [31:0] s_a0, s_d0, s_a1, s_d1, ma, md;
        s_rst = Reset;
        s_r0 = bus.Req0; s_w0 = bus.We0; s_a0 = bus.Addr0; s_d0 = bus.WData0;
        s_r1 = bus.Req1; s_w1 = bus.We1; s_a1 = bus.Addr1; s_d1 = bus.WData1;
        mw = bus.MemWrite; ma = bus.MemAddr; md = bus.MemWriteData;
        @(posedge Clk);
        if (mw) mem[ma[3:0]] = md;
        model_edge(s_rst, s_r0, s_w0, s_a0, s_d0, s_r1, s_w1, s_a1, s_d1);
        #1;
    endtask

    task automatic check_now();
        @(negedge Clk);
        check_val("gnt0",    bus.Gnt0,         e_gnt0);
        check_val("gnt1",    bus.Gnt1,         e_gnt1);
        check_val("busy",    bus.Busy,         e_busy);
        check_val("rvalid0", bus.RValid0,      e_rv0);
        check_val("rvalid1", bus.RValid1,      e_rv1);
        check_val("rdata0",  bus.RData0,       e_rd0);
        check_val("rdata1",  bus.RData1,       e_rd1);
        check_val("memaddr", bus.MemAddr,      e_addr);
        check_val("memwdat", bus.MemWriteData, e_wdata);
        check_val("memwr",   bus.MemWrite,     e_busy &&  pend_we && !Reset);
        check_val("memrd",   bus.MemRead,      e_busy && !pend_we && !Reset);
    endtask

    task automatic cyc(input logic rst,
                       input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        step();
        drive(rst, r0, w0, a0, d0, r1, w1, a1, d1);
        check_now();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic        rq0, wq0, rq1, wq1, rst;
        logic [31:0] aq0, dq0, aq1, dq1;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = i * 32'h01010101;
            ref_mem[i] = i * 32'h01010101;
        end
        mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        m_last = 1'b1; pend_v = 1'b0; pend_port = 1'b0; pend_we = 1'b0;
        pend_addr = 32'h0; pend_wdata = 32'h0;
        e_rd0 = 32'h0; e_rd1 = 32'h0; e_addr = 32'h0; e_wdata = 32'h0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();

        // Port-0 read of address 5
        cyc(1'b0, 1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        check_val("r031_gnt0", bus.Gnt0, 1'b1);
        check_val("r031_addr", bus.MemAddr, 32'd5);
        check_val("r031_rd",   bus.MemRead, 1'b1);
        idle();
        check_val("r031_rv0",  bus.RValid0, 1'b1);
        check_val("r031_data", bus.RData0, 32'hDEADBEEF);

        // Port-1 write then port-0 readback
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd3, 32'h1234);
        idle();
        check_val("r032_gnt1", bus.Gnt1, 1'b1);
        check_val("r032_wr",   bus.MemWrite, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        idle();
        check_val("r032_data", bus.RData0, 32'h1234);
        check_val("r032_rv1",  bus.RValid1, 1'b0);

        // Simultaneous first requests after reset; port-1 request during port-0 ACCESS
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 1'b0, 32'd2, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd2, 32'h0);
        check_val("r034_gnt0", bus.Gnt0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd2, 32'h0);
        check_val("r036_nogn", bus.Gnt1, 1'b0);
        idle();
        check_val("r036_gnt1", bus.Gnt1, 1'b1);

        // Both ports requesting continuously: grants alternate
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 1'b0, 32'd2, 32'h0);
        idle();
        idle();

        // Reset during a write ACCESS to address 7
        cyc(1'b0, 1'b1, 1'b1, 32'd7, 32'hCAFE0000, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("r035_wr",   bus.MemWrite, 1'b0);
        idle();
        check_val("r035_busy", bus.Busy, 1'b0);
        check_val("r035_rv0",  bus.RValid0, 1'b0);
        check_val("r035_mem7", mem[7], 32'h07070707);

        // Random traffic: requesters hold until granted, sometimes re-request immediately
        rq0 = 1'b0; wq0 = 1'b0; aq0 = 32'h0; dq0 = 32'h0;
        rq1 = 1'b0; wq1 = 1'b0; aq1 = 32'h0; dq1 = 32'h0;
        for (int n = 0; n < 800; n++) begin
            step();
            if (e_gnt0 || !rq0) begin
                rq0 = (e_gnt0 ? ($urandom_range(1, 0) == 0) : ($urandom_range(2, 0) == 0));
                wq0 = $urandom_range(1, 0) == 1;
                aq0 = $urandom_range(15, 0);
                dq0 = $urandom;
            end
            if (e_gnt1 || !rq1) begin
                rq1 = (e_gnt1 ? ($urandom_range(1, 0) == 0) : ($urandom_range(2, 0) == 0));
                wq1 = $urandom_range(1, 0) == 1;
                aq1 = $urandom_range(15, 0);
                dq1 = $urandom;
            end
            rst = ($urandom_range(39, 0) == 0);
            drive(rst, rq0, wq0, aq0, dq0, rq1, wq1, aq1, dq1);
            check_now();
        end
        for (int i = 0; i < 16; i++) check_val("mem_img", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
